gpu_rect_raster: RTL and testbench

//   Upstream pixel source for the GPU SRAM writer: accepts one filled-rectangle command, clips it to the
//   640x400 frame, and emits one (SRAM address, 64-bit colour) pair per pixel in raster order.

---
 rtl/gpu_pkg.sv | 21 ++
 rtl/gpu_rect_clip.sv | 26 ++
 rtl/gpu_rect_raster.sv | 133 +++++++++++++
 tb/tb_gpu_rect_raster.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: frame geometry defaults, colour field positions and rectangle FSM states.
package gpu_pkg;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 400;
    localparam int DEF_ADDR_W = 18;

    // Command colour word layout {unused, B, G, R}
    localparam int COLOR_R_LSB = 0;
    localparam int COLOR_G_LSB = 16;
    localparam int COLOR_B_LSB = 32;
    localparam int COLOR_FIELD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gpu_rect_clip.sv
// Combinational clip stage: clamps the far rectangle corner to the frame and flags empty commands.
module gpu_rect_clip
    import gpu_pkg::*;
#(
    parameter int H_RES = DEF_H_RES,
    parameter int V_RES = DEF_V_RES
) (
    input  logic [9:0] x0,
    input  logic [9:0] x1,
    input  logic [9:0] y0,
    input  logic [9:0] y1,
    output logic [9:0] x1c,
    output logic [9:0] y1c,
    output logic       empty
);

    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [9:0] Y_MAX = 10'(V_RES - 1);

    always_comb begin
        x1c   = (x1 > X_MAX) ? X_MAX : x1;
        y1c   = (y1 > Y_MAX) ? Y_MAX : y1;
        empty = (x0 > x1c) || (y0 > y1c) || (x0 > X_MAX) || (y0 > Y_MAX);
    end

endmodule

// File: rtl/gpu_rect_raster.sv
// Filled-rectangle rasteriser: one command in, one (address, colour) per clipped pixel out in raster order.
// Define GPU_RECT_OUTLINE_EN to honour I_CMD_OUTLINE (border pixels only).
module gpu_rect_raster
    import gpu_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_CMD_VALID,
    output logic              O_CMD_READY,
    input  logic [9:0]        I_CMD_X0,
    input  logic [9:0]        I_CMD_X1,
    input  logic [9:0]        I_CMD_Y0,
    input  logic [9:0]        I_CMD_Y1,
    input  logic [63:0]       I_CMD_COLOR,
    input  logic              I_CMD_OUTLINE,
    output logic              O_PIX_VALID,
    input  logic              I_PIX_READY,
    output logic [ADDR_W-1:0] O_PIX_ADDR,
    output logic [63:0]       O_PIX_COLOR,
    output logic              O_BUSY,
    output logic              O_DONE,
    output state_t            O_STATE
);

    // Both streams are valid/ready: a transfer happens on a rising edge where valid and ready are
    // both high; the offering side holds its payload and valid steady until that edge.

`ifdef GPU_RECT_OUTLINE_EN
    localparam bit OUTLINE_EN = 1'b1;
`else
    localparam bit OUTLINE_EN = 1'b0;
`endif

    state_t              state, state_n;
    logic [9:0]          cmd_x0, cmd_x1, cmd_y0, cmd_y1;
    logic [63:0]         color;
    logic                outline;
    logic [9:0]          x, y, x1c, y1c;
    logic [ADDR_W-1:0]   row_base;
    logic [9:0]          x1c_w, y1c_w;
    logic                empty_w;
    logic [ADDR_W-1:0]   y0_ext;
    logic                hs, last_x, last_y, skip;

    gpu_rect_clip #(.H_RES(H_RES), .V_RES(V_RES)) u_clip (
        .x0   (cmd_x0),
        .x1   (cmd_x1),
        .y0   (cmd_y0),
        .y1   (cmd_y1),
        .x1c  (x1c_w),
        .y1c  (y1c_w),
        .empty(empty_w)
    );

    always_comb begin
        state_n = state;
        y0_ext  = ADDR_W'(cmd_y0);
        hs      = (state == RUN) && I_PIX_READY;
        last_x  = (x == x1c);
        last_y  = (y == y1c);
        // Interior rows of an outline jump from the left edge straight to the right edge.
        skip    = OUTLINE_EN && outline && (y != cmd_y0) && (y != y1c) && (x == cmd_x0);
        case (state)
            IDLE:    if (I_CMD_VALID) state_n = SETUP;
            SETUP:   state_n = empty_w ? DONE : RUN;
            RUN:     if (hs && last_x && last_y) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state    <= IDLE;
            cmd_x0   <= '0;
            cmd_x1   <= '0;
            cmd_y0   <= '0;
            cmd_y1   <= '0;
            color    <= '0;
            outline  <= 1'b0;
            x        <= '0;
            y        <= '0;
            x1c      <= '0;
            y1c      <= '0;
            row_base <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (I_CMD_VALID) begin
                    cmd_x0  <= I_CMD_X0;
                    cmd_x1  <= I_CMD_X1;
                    cmd_y0  <= I_CMD_Y0;
                    cmd_y1  <= I_CMD_Y1;
                    color   <= I_CMD_COLOR;
                    outline <= I_CMD_OUTLINE;
                end
                SETUP: begin
                    x   <= cmd_x0;
                    y   <= cmd_y0;
                    x1c <= x1c_w;
                    y1c <= y1c_w;
                    // y*640 as y*512 + y*128
                    row_base <= (y0_ext << 9) + (y0_ext << 7);
                end
                RUN: if (hs) begin
                    if (last_x) begin
                        x        <= cmd_x0;
                        y        <= y + 10'd1;
                        row_base <= row_base + ADDR_W'(H_RES);
                    end else if (skip) begin
                        x <= x1c;
                    end else begin
                        x <= x + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_CMD_READY = (state == IDLE);
    assign O_PIX_VALID = (state == RUN);
    assign O_PIX_ADDR  = row_base + ADDR_W'(x);
    assign O_PIX_COLOR = color;
    assign O_BUSY      = (state != IDLE);
    assign O_DONE      = (state == DONE);
    assign O_STATE     = state;

endmodule

// File: tb/tb_gpu_rect_raster.sv
// Directed bench for gpu_rect_raster; outline expectations follow GPU_RECT_OUTLINE_EN.
module tb_gpu_rect_raster;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0, cmd_x1 = '0, cmd_y0 = '0, cmd_y1 = '0;
    logic [63:0] cmd_color = '0;
    logic        cmd_outline = 1'b0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [17:0] pix_addr;
    logic [63:0] pix_color;
    logic        busy, done;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    gpu_rect_raster dut (
        .I_CLK(clk), .I_RST_N(rst_n),
        .I_CMD_VALID(cmd_valid), .O_CMD_READY(cmd_ready),
        .I_CMD_X0(cmd_x0), .I_CMD_X1(cmd_x1), .I_CMD_Y0(cmd_y0), .I_CMD_Y1(cmd_y1),
        .I_CMD_COLOR(cmd_color), .I_CMD_OUTLINE(cmd_outline),
        .O_PIX_VALID(pix_valid), .I_PIX_READY(pix_ready),
        .O_PIX_ADDR(pix_addr), .O_PIX_COLOR(pix_color),
        .O_BUSY(busy), .O_DONE(done), .O_STATE(dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
        chk({tag, "_pix_addr"}, 64'(pix_addr), 64'd0);
        chk({tag, "_pix_color"}, pix_color, 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
    endtask

    // Accept in the current cycle; returns in the cycle after SETUP (first pixel cycle).
    task automatic send_cmd(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] x1,
                            input logic [9:0] y1, input logic [63:0] col, input logic ol);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1;
        cmd_color = col; cmd_outline = ol;
        step();
        // Junk on the command bus during BUSY must be ignored.
        cmd_valid = 1'b0;
        cmd_x0 = 10'($urandom); cmd_x1 = 10'($urandom);
        cmd_y0 = 10'($urandom); cmd_y1 = 10'($urandom);
        cmd_color = {$urandom, $urandom};
        chk("setup_busy", 64'(busy), 64'd1);
        chk("setup_no_valid", 64'(pix_valid), 64'd0);
        chk("setup_not_ready", 64'(cmd_ready), 64'd0);
        step();
    endtask

    task automatic drain(input string tag, input logic [63:0] col, input bit rand_ready);
        int budget = 600;
        bit hs;
        bit stalled = 1'b0;
        logic [17:0] held_addr = '0;
        while (exp_q.size() > 0 && budget > 0) begin
            chk({tag, "_valid"}, 64'(pix_valid), 64'd1);
            chk({tag, "_done_low"}, 64'(done), 64'd0);
            if (pix_valid) begin
                chk({tag, "_addr"}, 64'(pix_addr), 64'(exp_q[0]));
                chk({tag, "_color"}, pix_color, col);
                if (stalled) chk({tag, "_stall_hold"}, 64'(pix_addr), 64'(held_addr));
            end
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = pix_valid && pix_ready;
            stalled = pix_valid && !pix_ready;
            held_addr = pix_addr;
            step();
            if (hs) void'(exp_q.pop_front());
            budget--;
        end
        chk({tag, "_timeout_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        pix_ready = 1'b1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd1);
        chk({tag, "_done_no_valid"}, 64'(pix_valid), 64'd0);
        step();
        chk({tag, "_done_clear"}, 64'(done), 64'd0);
        chk({tag, "_idle_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #12;
        chk_reset_values("reset");
        rst_n = 1'b1;
        step();
        chk_reset_values("post_reset");

        // 1: small 3x2 fill, ready held high
        pix_ready = 1'b1;
        exp_q = '{18'd1922, 18'd1923, 18'd1924, 18'd2562, 18'd2563, 18'd2564};
        send_cmd(10'd2, 10'd3, 10'd4, 10'd4, 64'h0000_000F_00F0_0F00, 1'b0);
        drain("t1", 64'h0000_000F_00F0_0F00, 1'b0);

        // 2: clipped at the bottom-right corner
        for (int yy = 395; yy <= 399; yy++)
            for (int xx = 630; xx <= 639; xx++)
                exp_q.push_back(18'(yy * 640 + xx));
        chk("t2_count", 64'(exp_q.size()), 64'd50);
        chk("t2_last", 64'(exp_q[$]), 64'd255999);
        send_cmd(10'd630, 10'd395, 10'd700, 10'd500, 64'h1234_5678_9ABC_DEF0, 1'b0);
        drain("t2", 64'h1234_5678_9ABC_DEF0, 1'b0);

        // 3: empty command (X0 > X1)
        send_cmd(10'd10, 10'd0, 10'd5, 10'd0, 64'hAAAA, 1'b0);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_no_valid", 64'(pix_valid), 64'd0);
        step();
        chk("t3_ready_back", 64'(cmd_ready), 64'd1);
        chk("t3_done_clear", 64'(done), 64'd0);

        // 4: 3x3 with random ready stalls
        exp_q = '{18'd641, 18'd642, 18'd643, 18'd1281, 18'd1282, 18'd1283,
                  18'd1921, 18'd1922, 18'd1923};
        send_cmd(10'd1, 10'd1, 10'd3, 10'd3, 64'h0000_0001_0002_0003, 1'b0);
        drain("t4", 64'h0000_0001_0002_0003, 1'b1);

        // 5: reset mid-RUN, then a single-pixel command
        pix_ready = 1'b1;
        send_cmd(10'd0, 10'd0, 10'd9, 10'd9, 64'hFFFF, 1'b0);
        step();
        step();
        chk("t5_running", 64'(pix_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_values("t5_async");
        step();
        chk_reset_values("t5_edge");
        rst_n = 1'b1;
        step();
        chk_reset_values("t5_release");
        exp_q = '{18'd645};
        send_cmd(10'd5, 10'd1, 10'd5, 10'd1, 64'h0000_0042_0000_0000, 1'b0);
        drain("t5_single", 64'h0000_0042_0000_0000, 1'b0);

        // 6: outline request on a 4x4
`ifdef GPU_RECT_OUTLINE_EN
        exp_q = '{18'd0, 18'd1, 18'd2, 18'd3, 18'd640, 18'd643, 18'd1280, 18'd1283,
                  18'd1920, 18'd1921, 18'd1922, 18'd1923};
`else
        for (int yy = 0; yy <= 3; yy++)
            for (int xx = 0; xx <= 3; xx++)
                exp_q.push_back(18'(yy * 640 + xx));
`endif
        send_cmd(10'd0, 10'd0, 10'd3, 10'd3, 64'h0000_0777_0000_0001, 1'b1);
        drain("t6", 64'h0000_0777_0000_0001, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
